// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: packet-granular round-robin arbiter that merges NUM_SOURCES
// UDP payload streams into one, with overlength truncation and a stall watchdog.
module udp_tx_arbiter #(
  parameter int unsigned NUM_SOURCES       = 4,
  parameter int unsigned AXI_DATA_WIDTH    = 8,
  parameter int unsigned MAX_PACKET_LENGTH = 1472,
  parameter int unsigned STALL_TIMEOUT     = 1024
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_SOURCES-1:0]                   enable_mask,
  input  logic [NUM_SOURCES-1:0]                   in_valid,
  input  logic [NUM_SOURCES*AXI_DATA_WIDTH-1:0]    in_data,
  input  logic [NUM_SOURCES-1:0]                   in_last,
  output logic [NUM_SOURCES-1:0]                   in_ready,
  output logic                                     out_valid,
  output logic [AXI_DATA_WIDTH-1:0]                out_data,
  output logic                                     out_last,
  output logic                                     out_abort,
  output logic [$clog2(NUM_SOURCES)-1:0]           out_source,
  input  logic                                     out_ready,
  output logic [15:0]                              abort_count
);

  localparam int unsigned SW = $clog2(NUM_SOURCES);
  localparam int unsigned DW = AXI_DATA_WIDTH;
  localparam int unsigned BW = ($clog2(MAX_PACKET_LENGTH) > 11) ? $clog2(MAX_PACKET_LENGTH) : 11;
  localparam int unsigned CW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_PACKET_LENGTH - 1);
  localparam logic [CW-1:0] STALL_LIM = CW'(STALL_TIMEOUT - 1);
  localparam logic [SW-1:0] LAST_SRC  = SW'(NUM_SOURCES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2,
    S_ABORT  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   grant, grant_nxt;
  logic [SW-1:0]   rr_ptr, rr_nxt;
  logic [BW-1:0]   beat_cnt, beat_nxt;
  logic [CW-1:0]   stall_cnt, stall_nxt;
  logic [15:0]     abort_nxt;
  logic            abort_inc;

  logic [NUM_SOURCES-1:0] req;
  logic [NUM_SOURCES-1:0] grant_oh;
  logic [SW-1:0]          pick;
  logic                   pick_valid;
  logic [SW-1:0]          rr_after;
  logic                   g_valid;
  logic                   g_last;
  logic [DW-1:0]          g_data;
  logic                   at_max;

  // Round-robin search: first requesting source at or after rr_ptr.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    req        = in_valid & enable_mask;
    pick       = '0;
    pick_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_SOURCES) idx = idx - NUM_SOURCES;
      if (!pick_valid && req[SW'(idx)]) begin
        pick_valid = 1'b1;
        pick       = SW'(idx);
      end
    end
  end

  // Selected-source views and the pointer value used after a packet ends.
  always_comb begin
    g_data = '0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      if (SW'(k) == grant) g_data = in_data[k*DW +: DW];
    end
    g_valid  = in_valid[grant];
    g_last   = in_last[grant];
    grant_oh = {{(NUM_SOURCES-1){1'b0}}, 1'b1} << grant;
    rr_after = (grant == LAST_SRC) ? '0 : grant + SW'(1);
    at_max   = (beat_cnt == LAST_BEAT);
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    beat_nxt  = beat_cnt;
    stall_nxt = stall_cnt;
    abort_inc = 1'b0;
    in_ready  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_abort = 1'b0;

    unique case (state)
      S_IDLE: begin
        beat_nxt  = '0;
        stall_nxt = '0;
        if (pick_valid) begin
          grant_nxt = pick;
          state_nxt = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        out_valid = g_valid;
        out_data  = g_data;
        out_last  = g_last | at_max;
        out_abort = at_max & ~g_last;
        in_ready  = grant_oh & {NUM_SOURCES{out_ready}};
        if (g_valid) begin
          stall_nxt = '0;
          if (out_ready) begin
            beat_nxt = beat_cnt + BW'(1);
            if (g_last) begin
              state_nxt = S_IDLE;
              rr_nxt    = rr_after;
              beat_nxt  = '0;
            end else if (at_max) begin
              state_nxt = S_DRAIN;
              abort_inc = 1'b1;
            end
          end
        end else if (stall_cnt == STALL_LIM) begin
          state_nxt = S_ABORT;
          abort_inc = 1'b1;
        end else begin
          stall_nxt = stall_cnt + CW'(1);
        end
      end

      S_DRAIN: begin
        in_ready = grant_oh;
        if (g_valid && g_last) begin
          state_nxt = S_IDLE;
          rr_nxt    = rr_after;
          beat_nxt  = '0;
        end
      end

      S_ABORT: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_abort = 1'b1;
        if (out_ready) state_nxt = S_DRAIN;
      end

      default: state_nxt = S_IDLE;
    endcase

    abort_nxt = (abort_inc && (abort_count != 16'hFFFF)) ? abort_count + 16'd1 : abort_count;
  end

  assign out_source = grant;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      stall_cnt   <= '0;
      abort_count <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      rr_ptr      <= rr_nxt;
      beat_cnt    <= beat_nxt;
      stall_cnt   <= stall_nxt;
      abort_count <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomized scoreboard bench for udp_tx_arbiter.
module tb_udp_tx_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned MAXL = 1472;
  localparam int unsigned STO  = 1024;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      enable_mask;
  logic [N-1:0]      in_valid;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      in_last;
  logic [N-1:0]      in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              out_abort;
  logic [1:0]        out_source;
  logic              out_ready;
  logic [15:0]       abort_count;

  always #5 clk = ~clk;

  udp_tx_arbiter #(
    .NUM_SOURCES(N), .AXI_DATA_WIDTH(DW),
    .MAX_PACKET_LENGTH(MAXL), .STALL_TIMEOUT(STO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_mask(enable_mask),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_abort(out_abort), .out_source(out_source), .out_ready(out_ready),
    .abort_count(abort_count)
  );

  typedef struct packed {logic [7:0] data; logic last; logic [15:0] gap;} drv_beat_t;
  typedef struct packed {logic [7:0] data; logic last; logic abort;} exp_beat_t;

  drv_beat_t   dq[N][$];
  exp_beat_t   eq[N][$];
  int unsigned erd[N];

  logic        act[N];
  int unsigned gap_left[N];
  bit          rand_ready;
  int unsigned exp_aborts;
  bit          timed_out;
  int          chk_seq;
  int unsigned chk_abort_exp;
  logic [N-1:0] tk_ihs;
  logic         tk_ohs;
  logic [1:0]   tk_src;

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    tk_ihs = in_valid & in_ready;
    tk_ohs = out_valid & out_ready;
    tk_src = out_source;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (tk_ihs[i]) begin
        dq[i].delete(0);
        act[i] = 1'b0;
      end
      if (!act[i] && dq[i].size() > 0) begin
        act[i]      = 1'b1;
        gap_left[i] = 32'(dq[i][0].gap);
      end
      if (act[i] && gap_left[i] == 0) begin
        in_valid[i]          = 1'b1;
        in_data[i*DW +: DW]  = dq[i][0].data;
        in_last[i]           = dq[i][0].last;
      end else begin
        if (act[i]) gap_left[i] = gap_left[i] - 1;
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
      end
    end
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  // Queue a packet for a source and derive what must come out of the arbiter.
  task automatic push_pkt(input int s, input int unsigned len, input int unsigned stall_at,
                          input int unsigned stall_gap, input int unsigned maxgap);
    int unsigned lim;
    bit stall_ab;
    drv_beat_t d;
    lim      = (len < MAXL) ? len : MAXL;
    stall_ab = (stall_at > 0) && (stall_at < lim) && (stall_gap >= STO);
    for (int unsigned b = 0; b < len; b++) begin
      d.data = 8'($urandom);
      d.last = (b == len - 1);
      d.gap  = (stall_at > 0 && b == stall_at) ? 16'(stall_gap) : 16'($urandom_range(0, maxgap));
      dq[s].push_back(d);
      if (stall_ab) begin
        if (b < stall_at) eq[s].push_back('{data: d.data, last: 1'b0, abort: 1'b0});
        if (b == stall_at) eq[s].push_back('{data: 8'h00, last: 1'b1, abort: 1'b1});
      end else if (b < lim) begin
        eq[s].push_back('{data: d.data, last: (b == lim - 1),
                          abort: (b == lim - 1) && (len > MAXL)});
      end
    end
    if (stall_ab || len > MAXL) exp_aborts++;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (dq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_drain(input int unsigned budget);
    int unsigned k;
    k = 0;
    while (!all_empty() && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) timed_out = 1'b1;
    repeat (4) tick();
  endtask

  task automatic request_check();
    chk_abort_exp = exp_aborts;
    chk_seq++;
    tick();
    tick();
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [N-1:0] req;
  bit  busy = 1'b0;
  int  owner = 0;
  int  rr = 0;
  int  last_owner = 0;
  bit  rst_done = 1'b0;
  int  seen_seq = 0;

  task automatic chk(input string nm, input logic [31:0] actual, input logic [31:0] required);
    n_cmp++;
    if (actual !== required) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, actual, required, $time);
    end
  endtask

  function automatic int pick_rr(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // Packet-level arbitration model plus beat scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (!rst_done) begin
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_abort", 32'(out_abort), 0);
        chk("rst_out_source", 32'(out_source), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_abort_count", 32'(abort_count), 0);
        rst_done = 1'b1;
      end
      busy = 1'b0;
      rr = 0;
      last_owner = 0;
      for (int i = 0; i < N; i++) erd[i] = eq[i].size();
    end else begin
      rst_done = 1'b0;
      if (seen_seq != chk_seq) begin
        seen_seq = chk_seq;
        chk("abort_count", 32'(abort_count), chk_abort_exp);
        chk("no_timeout", 32'(timed_out), 0);
        for (int i = 0; i < N; i++) chk("exp_consumed", erd[i], eq[i].size());
      end
      if (!busy) begin
        chk("idle_in_ready", 32'(in_ready), 0);
        chk("idle_out_source", 32'(out_source), last_owner);
        req = in_valid & enable_mask;
        if (req != '0) begin
          owner = pick_rr(req, rr);
          busy  = 1'b1;
        end
      end else begin
        chk("grant_source", 32'(out_source), owner);
        chk("other_ready", 32'(in_ready & ~(N'(1) << owner)), 0);
        if (in_valid[owner] && in_ready[owner] && in_last[owner]) begin
          busy = 1'b0;
          rr = (owner + 1) % N;
          last_owner = owner;
        end
      end
      if (out_valid && out_ready) begin
        if (erd[out_source] >= eq[out_source].size()) begin
          chk("unexpected_beat", 32'(out_source) + 1, 0);
        end else begin
          chk("beat_data_last_abort", 32'({out_data, out_last, out_abort}),
              32'(eq[out_source][erd[out_source]]));
          erd[out_source]++;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int unsigned k;
    int seen;
    rst_n = 1'b0; enable_mask = '1; in_valid = '0; in_data = '0; in_last = '0;
    out_ready = 1'b1; rand_ready = 1'b0; exp_aborts = 0; timed_out = 1'b0;
    chk_seq = 0; chk_abort_exp = 0;
    for (int i = 0; i < N; i++) begin act[i] = 1'b0; gap_left[i] = 0; erd[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single source, 10 beats, always ready
    push_pkt(0, 10, 0, 0, 0);
    run_drain(200);

    // all four sources continuously requesting 3-beat packets
    for (int p = 0; p < 4; p++) for (int s = 0; s < N; s++) push_pkt(s, 3, 0, 0, 0);
    run_drain(500);

    // random traffic with gaps and downstream back-pressure
    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) push_pkt($urandom_range(0, N-1), $urandom_range(1, 20), 0, 0, 2);
    run_drain(5000);

    // overlength and exact-length boundaries
    push_pkt(2, 1480, 0, 0, 0);
    push_pkt(3, 4, 0, 0, 0);
    push_pkt(1, MAXL, 0, 0, 0);
    push_pkt(1, MAXL + 1, 0, 0, 0);
    run_drain(20000);

    // stall of exactly the timeout, then one cycle short of it
    push_pkt(1, 12, 5, STO, 0);
    run_drain(5000);
    push_pkt(1, 12, 5, STO - 1, 0);
    run_drain(5000);

    // enable mask restricts grants; clearing the owner's bit mid-packet is harmless
    enable_mask = 4'b0101;
    for (int s = 0; s < N; s++) begin push_pkt(s, 4, 0, 0, 1); push_pkt(s, 4, 0, 0, 1); end
    k = 0;
    while ((dq[0].size() != 0 || dq[2].size() != 0) && k < 2000) begin tick(); k++; end
    if (k >= 2000) timed_out = 1'b1;
    repeat (3) tick();
    push_pkt(0, 30, 0, 0, 0);
    push_pkt(2, 5, 0, 0, 0);
    seen = 0; k = 0;
    while (seen < 5 && k < 2000) begin
      tick();
      if (tk_ohs && tk_src == 2'd0) seen++;
      k++;
    end
    if (k >= 2000) timed_out = 1'b1;
    enable_mask = 4'b0100;
    k = 0;
    while (dq[0].size() != 0 && k < 2000) begin tick(); k++; end
    if (k >= 2000) timed_out = 1'b1;
    enable_mask = 4'b1111;
    run_drain(2000);
    request_check();

    // asynchronous reset in the middle of a packet
    rand_ready = 1'b0;
    push_pkt(0, 10, 0, 0, 0);
    seen = 0; k = 0;
    while (seen < 4 && k < 200) begin
      tick();
      if (tk_ohs) seen++;
      k++;
    end
    if (k >= 200) timed_out = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin dq[i].delete(); act[i] = 1'b0; end
    in_valid = '0; in_last = '0;
    exp_aborts = 0;
    repeat (3) tick();
    rst_n = 1'b1;

    // arbitration restarts from pointer 0
    push_pkt(3, 3, 0, 0, 0);
    push_pkt(1, 3, 0, 0, 0);
    run_drain(200);
    request_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
